triggered_pulse_generator: RTL and testbench
============================================

Name: triggered_pulse_generator

Overview:
- Consumes the single-cycle positive-edge pulses produced by the feedback chain's edge detector.
- On each accepted trigger it waits a programmable delay, then drives a programmable-width output pulse. This pulse is used as the feedback kick and gate signal.
- Triggers that arrive while a delay/pulse sequence is in progress are dropped.
- Sits directly downstream of the edge detector; delay and width come from configuration registers.

Parameters:
- DELAY_W, 16, width of delay_i and of the internal delay counter
- WIDTH_W, 16, width of width_i and of the internal width counter
- MISS_W, 16, width of missed_o (used only with the optional feature)

Ports:
- clk_i  in  1  system clock; all logic on its rising edge
- rst_i  in  1  synchronous, active-high reset
- trig_i  in  1  single-cycle trigger pulse from the edge detector
- enable_i  in  1  block enable; low = triggers ignored and any sequence aborted
- delay_i  in  DELAY_W  cycles from trigger to first pulse cycle; sampled on trigger accept
- width_i  in  WIDTH_W  pulse length in cycles; sampled on trigger accept
- pulse_o  out  1  registered output pulse
- busy_o  out  1  high while a sequence (delay or pulse) is in progress
- missed_o  out  MISS_W  saturating count of dropped triggers (only with TRIG_PULSE_MISS_CNT_EN)

Behaviour:
- Reset: the clock is the only clock domain. When rst_i=1 at an edge: state=IDLE, counters=0, pulse_o=0, busy_o=0, missed_o=0. Reset has priority over everything, including mid-sequence.
- FSM states: IDLE, DELAY, PULSE.
- Trigger accept:
  - Condition: state IDLE, enable_i=1, trig_i=1 at the edge ending cycle k.
  - Latch D=delay_i and W=width_i at that edge. Later changes to delay_i/width_i do not affect a running sequence.
- Transitions from accept:
  - W=0: accepted but no output; stay IDLE; busy_o stays 0.
  - D=0, W>0: go to PULSE; pulse_o=1 in cycles k+1 .. k+W.
  - D>0, W>0: go to DELAY for D cycles (k+1 .. k+D), then PULSE; pulse_o=1 in cycles k+D+1 .. k+D+W.
- Return to IDLE: after the last PULSE cycle; pulse_o=0 and busy_o=0 from cycle k+D+W+1.
- Latency and rate:
  - Minimum trigger-to-pulse latency is 1 cycle (output registered, no combinational path from trig_i to pulse_o).
  - Minimum accepted trigger spacing is D+W+1 cycles.
- busy_o: equals (state != IDLE), registered.
- Dropped trigger: trig_i=1 while busy_o=1, including in the last PULSE cycle. The trigger is ignored and the running sequence is unaffected.
- enable_i:
  - trig_i while enable_i=0 is ignored and not counted as missed.
  - enable_i=0 during DELAY/PULSE: state=IDLE at the next edge; pulse_o and busy_o go low the following cycle. A truncated pulse is acceptable.
- Simultaneous events:
  - trig_i and enable_i rising together: trigger accepted.
  - trig_i with rst_i: reset wins, nothing latched.
- Counters:
  - Delay and width counters are loaded with D-1 / W-1 and count down to 0.
  - No wrap-around: maximum values 2^DELAY_W-1 and 2^WIDTH_W-1 are honoured exactly.

Optional Feature:
- Macro: TRIG_PULSE_MISS_CNT_EN.
- Defined:
  - missed_o exists and increments by 1 for each dropped trigger (trig_i=1, enable_i=1, busy_o=1).
  - Saturates at 2^MISS_W-1; cleared only by rst_i.
- Undefined: the missed_o port and counter are absent; dropped triggers are silently discarded.

Decomposition:
- Shared package trig_pulse_pkg:
  - state enum (IDLE, DELAY, PULSE)
  - default width constants DELAY_W_DEF=16, WIDTH_W_DEF=16, MISS_W_DEF=16
- Sub-module load_down_counter, instantiated twice (delay and width):
  - Ports: clk_i, rst_i, load_i, value_i, en_i, zero_o.
  - Loadable down-counter, synchronous active-high reset.

Test Plan:
- Basic timing: D=3, W=4, single trig_i at cycle 10 -> pulse_o=1 in cycles 14..17; busy_o=1 in cycles 11..17; both low at cycle 18.
- Zero delay: D=0, W=1, trig at cycle 5 -> pulse_o=1 only in cycle 6; zero-width: W=0, trig -> pulse_o and busy_o stay 0.
- Dropped trigger: D=2, W=2, triggers at cycles 0 and 3 -> one pulse in cycles 3..4; second trigger dropped; with TRIG_PULSE_MISS_CNT_EN, missed_o=1. Trigger at cycle 5 -> accepted.
- Parameter latching: trig with D=5, W=2; change delay_i to 1 at the next cycle -> pulse still in cycles k+6..k+7.
- Abort and reset:
  - enable_i dropped during PULSE -> pulse_o low within 2 cycles.
  - rst_i asserted mid-DELAY -> all outputs 0 the next cycle; no pulse appears afterward.
- Saturation (feature on, MISS_W=2): 5 dropped triggers during a long sequence -> missed_o stays at 3.

Source files
------------

// File: rtl/trig_pulse_pkg.sv
// Shared types and default widths for the triggered pulse generator.
package trig_pulse_pkg;

    localparam int DELAY_W_DEF = 16;
    localparam int WIDTH_W_DEF = 16;
    localparam int MISS_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

endpackage

// File: rtl/load_down_counter.sv
// Loadable down-counter that holds at zero; load takes priority over count.
module load_down_counter
    import trig_pulse_pkg::*;
#(
    parameter int W = DELAY_W_DEF
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/triggered_pulse_generator.sv
// Trigger -> programmable delay -> programmable-width registered pulse.
// Define TRIG_PULSE_MISS_CNT_EN to add the saturating dropped-trigger counter missed_o.
//
// state | meaning
// IDLE  | waiting for an accepted trigger
// DELAY | counting down the latched delay
// PULSE | driving pulse_o for the latched width
module triggered_pulse_generator
    import trig_pulse_pkg::*;
#(
    parameter int DELAY_W = DELAY_W_DEF,
    parameter int WIDTH_W = WIDTH_W_DEF
`ifdef TRIG_PULSE_MISS_CNT_EN
    ,
    parameter int MISS_W  = MISS_W_DEF
`endif
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               trig_i,
    input  logic               enable_i,
    input  logic [DELAY_W-1:0] delay_i,
    input  logic [WIDTH_W-1:0] width_i,
    output logic               pulse_o,
    output logic               busy_o
`ifdef TRIG_PULSE_MISS_CNT_EN
    ,
    output logic [MISS_W-1:0]  missed_o
`endif
);

    state_t               state_q, state_d;
    logic [WIDTH_W-1:0]   width_q;
    logic                 accept;

    logic                 dly_load, dly_en, dly_zero;
    logic [DELAY_W-1:0]   dly_val;
    logic                 wid_load, wid_en, wid_zero;
    logic [WIDTH_W-1:0]   wid_val;

    assign accept = (state_q == IDLE) && enable_i && trig_i;

    always_comb begin
        state_d  = state_q;
        dly_load = 1'b0;
        dly_en   = 1'b0;
        dly_val  = delay_i - DELAY_W'(1);
        wid_load = 1'b0;
        wid_en   = 1'b0;
        wid_val  = width_q - WIDTH_W'(1);
        case (state_q)
            IDLE: begin
                // A zero-width request is accepted but produces nothing.
                if (accept && (width_i != '0)) begin
                    if (delay_i == '0) begin
                        state_d  = PULSE;
                        wid_load = 1'b1;
                        wid_val  = width_i - WIDTH_W'(1);
                    end else begin
                        state_d  = DELAY;
                        dly_load = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (dly_zero) begin
                    state_d  = PULSE;
                    wid_load = 1'b1;
                end else begin
                    dly_en = 1'b1;
                end
            end
            PULSE: begin
                if (wid_zero) state_d = IDLE;
                else          wid_en  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (!enable_i) state_d = IDLE;
    end

    // Outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            width_q <= '0;
            pulse_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) width_q <= width_i;
            pulse_o <= (state_d == PULSE);
            busy_o  <= (state_d != IDLE);
        end
    end

    load_down_counter #(.W(DELAY_W)) u_delay_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (dly_load),
        .value_i (dly_val),
        .en_i    (dly_en),
        .zero_o  (dly_zero)
    );

    load_down_counter #(.W(WIDTH_W)) u_width_cnt (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load_i  (wid_load),
        .value_i (wid_val),
        .en_i    (wid_en),
        .zero_o  (wid_zero)
    );

`ifdef TRIG_PULSE_MISS_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            missed_o <= '0;
        end else if (trig_i && enable_i && busy_o && (missed_o != '1)) begin
            missed_o <= missed_o + MISS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_triggered_pulse_generator.sv
// Directed self-checking bench for triggered_pulse_generator (cycle c=0 is the trigger cycle).
module tb_triggered_pulse_generator;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        trig_i = 1'b0;
    logic        enable_i = 1'b1;
    logic [15:0] delay_i = '0;
    logic [15:0] width_i = '0;
    logic        pulse_o;
    logic        busy_o;
`ifdef TRIG_PULSE_MISS_CNT_EN
    logic [1:0]  missed_o;
    int          exp_missed = 0;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    triggered_pulse_generator #(
        .DELAY_W (16),
        .WIDTH_W (16)
`ifdef TRIG_PULSE_MISS_CNT_EN
        ,
        .MISS_W  (2)
`endif
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .trig_i   (trig_i),
        .enable_i (enable_i),
        .delay_i  (delay_i),
        .width_i  (width_i),
        .pulse_o  (pulse_o),
        .busy_o   (busy_o)
`ifdef TRIG_PULSE_MISS_CNT_EN
        ,
        .missed_o (missed_o)
`endif
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; trig_i = 1'b1; enable_i = 1'b1; delay_i = 16'd0; width_i = 16'd3;
        step();
        total++; if (pulse_o !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", pulse_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
`ifdef TRIG_PULSE_MISS_CNT_EN
        total++; if (missed_o !== 2'd0) begin bad++; $display("FAIL reset_missed got=%0d exp=0", missed_o); end
        exp_missed = 0;
`endif
        rst_i = 1'b0; trig_i = 1'b0;
        step();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_trig_latched got=%b exp=0", busy_o); end
        step();
    endtask

    task automatic test_basic();
        logic exp_p, exp_b;
        delay_i = 16'd3; width_i = 16'd4; trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            exp_p = (c >= 4 && c <= 7);
            exp_b = (c <= 7);
            total++; if (pulse_o !== exp_p) begin bad++; $display("FAIL basic_pulse c=%0d got=%b exp=%b", c, pulse_o, exp_p); end
            total++; if (busy_o !== exp_b) begin bad++; $display("FAIL basic_busy c=%0d got=%b exp=%b", c, busy_o, exp_b); end
            step();
        end
    endtask

    task automatic test_zero_delay_width();
        logic exp_p;
        delay_i = 16'd0; width_i = 16'd1; trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            exp_p = (c == 1);
            total++; if (pulse_o !== exp_p) begin bad++; $display("FAIL zero_delay_pulse c=%0d got=%b exp=%b", c, pulse_o, exp_p); end
            total++; if (busy_o !== exp_p) begin bad++; $display("FAIL zero_delay_busy c=%0d got=%b exp=%b", c, busy_o, exp_p); end
            step();
        end
        delay_i = 16'd2; width_i = 16'd0; trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            total++; if (pulse_o !== 1'b0) begin bad++; $display("FAIL zero_width_pulse c=%0d got=%b exp=0", c, pulse_o); end
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL zero_width_busy c=%0d got=%b exp=0", c, busy_o); end
            step();
        end
    endtask

    task automatic test_dropped();
        logic exp_p, exp_b;
        delay_i = 16'd2; width_i = 16'd2; trig_i = 1'b1;
        step();
        for (int c = 1; c <= 10; c++) begin
            trig_i = 1'b0;
            exp_p = (c == 3 || c == 4 || c == 8 || c == 9);
            exp_b = (c <= 4) || (c >= 6 && c <= 9);
            total++; if (pulse_o !== exp_p) begin bad++; $display("FAIL dropped_pulse c=%0d got=%b exp=%b", c, pulse_o, exp_p); end
            total++; if (busy_o !== exp_b) begin bad++; $display("FAIL dropped_busy c=%0d got=%b exp=%b", c, busy_o, exp_b); end
            if (c == 3 || c == 5) trig_i = 1'b1;
`ifdef TRIG_PULSE_MISS_CNT_EN
            if (c == 3 && exp_missed < 3) exp_missed++;
`endif
            step();
        end
        trig_i = 1'b0;
`ifdef TRIG_PULSE_MISS_CNT_EN
        total++; if (missed_o !== 2'(exp_missed)) begin bad++; $display("FAIL dropped_missed got=%0d exp=%0d", missed_o, exp_missed); end
`endif
    endtask

    task automatic test_back_to_back();
        logic exp_p;
        delay_i = 16'd0; width_i = 16'd2; trig_i = 1'b1;
        step();
        for (int c = 1; c <= 6; c++) begin
            trig_i = 1'b0;
            exp_p = (c == 1 || c == 2 || c == 4 || c == 5);
            total++; if (pulse_o !== exp_p) begin bad++; $display("FAIL b2b_pulse c=%0d got=%b exp=%b", c, pulse_o, exp_p); end
            total++; if (busy_o !== exp_p) begin bad++; $display("FAIL b2b_busy c=%0d got=%b exp=%b", c, busy_o, exp_p); end
            if (c == 2 || c == 3) trig_i = 1'b1;
`ifdef TRIG_PULSE_MISS_CNT_EN
            if (c == 2 && exp_missed < 3) exp_missed++;
`endif
            step();
        end
        trig_i = 1'b0;
`ifdef TRIG_PULSE_MISS_CNT_EN
        total++; if (missed_o !== 2'(exp_missed)) begin bad++; $display("FAIL b2b_missed got=%0d exp=%0d", missed_o, exp_missed); end
`endif
    endtask

    task automatic test_latch();
        logic exp_p, exp_b;
        delay_i = 16'd5; width_i = 16'd2; trig_i = 1'b1;
        step();
        trig_i = 1'b0; delay_i = 16'd1; width_i = 16'd7;
        for (int c = 1; c <= 9; c++) begin
            exp_p = (c == 6 || c == 7);
            exp_b = (c <= 7);
            total++; if (pulse_o !== exp_p) begin bad++; $display("FAIL latch_pulse c=%0d got=%b exp=%b", c, pulse_o, exp_p); end
            total++; if (busy_o !== exp_b) begin bad++; $display("FAIL latch_busy c=%0d got=%b exp=%b", c, busy_o, exp_b); end
            step();
        end
    endtask

    task automatic test_enable();
        logic exp_p, exp_b;
        delay_i = 16'd1; width_i = 16'd6; trig_i = 1'b1; enable_i = 1'b1;
        step();
        for (int c = 1; c <= 8; c++) begin
            trig_i = 1'b0;
            exp_p = (c == 2 || c == 3);
            exp_b = (c <= 3);
            if (c != 4) begin
                total++; if (pulse_o !== exp_p) begin bad++; $display("FAIL abort_pulse c=%0d got=%b exp=%b", c, pulse_o, exp_p); end
                total++; if (busy_o !== exp_b) begin bad++; $display("FAIL abort_busy c=%0d got=%b exp=%b", c, busy_o, exp_b); end
            end
            if (c == 3) enable_i = 1'b0;
            if (c == 6) trig_i = 1'b1;
            step();
        end
`ifdef TRIG_PULSE_MISS_CNT_EN
        total++; if (missed_o !== 2'(exp_missed)) begin bad++; $display("FAIL disabled_missed got=%0d exp=%0d", missed_o, exp_missed); end
`endif
        delay_i = 16'd0; width_i = 16'd1; enable_i = 1'b1; trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        total++; if (pulse_o !== 1'b1) begin bad++; $display("FAIL enable_rise_pulse got=%b exp=1", pulse_o); end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL enable_rise_busy got=%b exp=1", busy_o); end
        step();
        total++; if (pulse_o !== 1'b0) begin bad++; $display("FAIL enable_rise_end got=%b exp=0", pulse_o); end
    endtask

    task automatic test_reset_mid();
        delay_i = 16'd4; width_i = 16'd2; trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL rstmid_busy_pre got=%b exp=1", busy_o); end
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        for (int c = 3; c <= 10; c++) begin
            total++; if (pulse_o !== 1'b0) begin bad++; $display("FAIL rstmid_pulse c=%0d got=%b exp=0", c, pulse_o); end
            total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_busy c=%0d got=%b exp=0", c, busy_o); end
            step();
        end
`ifdef TRIG_PULSE_MISS_CNT_EN
        exp_missed = 0;
        total++; if (missed_o !== 2'd0) begin bad++; $display("FAIL rstmid_missed got=%0d exp=0", missed_o); end
`endif
    endtask

`ifdef TRIG_PULSE_MISS_CNT_EN
    task automatic test_saturation();
        delay_i = 16'd20; width_i = 16'd2; trig_i = 1'b1;
        step();
        trig_i = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            trig_i = 1'b1;
            step();
            trig_i = 1'b0;
            if (exp_missed < 3) exp_missed++;
            total++; if (missed_o !== 2'(exp_missed)) begin bad++; $display("FAIL sat_missed n=%0d got=%0d exp=%0d", n, missed_o, exp_missed); end
        end
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL sat_busy got=%b exp=1", busy_o); end
        repeat (30) step();
        total++; if (missed_o !== 2'd3) begin bad++; $display("FAIL sat_hold got=%0d exp=3", missed_o); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_delay_width();
        test_dropped();
        test_back_to_back();
        test_latch();
        test_enable();
        test_reset_mid();
`ifdef TRIG_PULSE_MISS_CNT_EN
        test_saturation();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
